// File: rtl/display_scan_controller.sv
//------------------------------------------------------------------------------
// display_scan_controller
//
// Multiplexed 4-digit display scanner. A prescaler divides the clock by
// SCAN_DIV. Each terminal count rotates a one-hot ring that selects the digit
// being driven. New 4-digit values are captured into a staging register on
// load. They are copied into the displayed (shadow) register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Parameters
//   SCAN_DIV       clock cycles each digit is driven (1..2^20)
//
// Optional build macro
//   LEADING_ZERO_BLANK_EN  also blank leading zero digits 3..1
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   enable         scan run (1) / hold (0)
//   load           capture data_3..data_0 into staging
//   data_3..data_0 BCD digits, data_3 most significant
//   ring_counter   one-hot digit select (0000 while disabled)
//   digit_out      shadow nibble of the selected digit
//   blank          selected digit must not be lit
//   frame_done     high during the step that wraps the ring 1000 -> 0001
//   load_ack       one-cycle pulse after the shadow register updates
//------------------------------------------------------------------------------
module display_scan_controller #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] data_3,
    input  logic [3:0] data_2,
    input  logic [3:0] data_1,
    input  logic [3:0] data_0,
    output logic [3:0] ring_counter,
    output logic [3:0] digit_out,
    output logic       blank,
    output logic       frame_done,
    output logic       load_ack
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_ring;
    logic [15:0]   r_staging;
    logic          r_pending;
    logic [15:0]   r_shadow;
    logic          r_load_ack;

    logic          w_step;
    logic          w_boundary;
    logic          w_update;
    logic [15:0]   w_data;
    logic [3:0]    w_digit;
    logic [3:0]    w_lz;

    assign w_data     = {data_3, data_2, data_1, data_0};
    assign w_step     = enable && (r_presc == TERM);
    assign w_boundary = w_step && r_ring[3];
    // A load in the boundary cycle itself counts, even with nothing pending.
    assign w_update   = w_boundary && (r_pending || load);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_ring  <= 4'b0001;
        end else if (enable) begin
            if (w_step) begin
                r_presc <= '0;
                r_ring  <= {r_ring[2:0], r_ring[3]};
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_staging  <= '0;
            r_pending  <= 1'b0;
            r_shadow   <= '0;
            r_load_ack <= 1'b0;
        end else begin
            if (load) begin
                r_staging <= w_data;
            end
            // Update wins over a coincident load: that load's data goes
            // straight to the shadow, so nothing remains pending.
            if (w_update) begin
                r_shadow  <= load ? w_data : r_staging;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_load_ack <= w_update;
        end
    end

    // And-or mux on the one-hot ring: no added latency from ring to digit.
    always_comb begin
        w_digit = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (r_ring[k]) begin
                w_digit = w_digit | r_shadow[4*k +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when it and every more significant digit are 0.
    always_comb begin
        w_lz    = '0;
        w_lz[3] = (r_shadow[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (r_shadow[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (r_shadow[7:4] == 4'd0);
    end
`else
    assign w_lz = '0;
`endif

    assign ring_counter = enable ? r_ring : 4'b0000;
    assign digit_out    = w_digit;
    assign blank        = !enable || (|(r_ring & w_lz));
    assign frame_done   = w_boundary;
    assign load_ack     = r_load_ack;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] data_3, data_2, data_1, data_0;
    logic [3:0] ring_counter;
    logic [3:0] digit_out;
    logic       blank;
    logic       frame_done;
    logic       load_ack;

    int total = 0;
    int bad   = 0;

    // Expected blank for leading-zero digits of shadow 0,0,4,2.
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    display_scan_controller #(.SCAN_DIV(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .data_3       (data_3),
        .data_2       (data_2),
        .data_1       (data_1),
        .data_0       (data_0),
        .ring_counter (ring_counter),
        .digit_out    (digit_out),
        .blank        (blank),
        .frame_done   (frame_done),
        .load_ack     (load_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_data(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
        data_3 = d3; data_2 = d2; data_1 = d1; data_0 = d0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        set_data(4'd0, 4'd0, 4'd0, 4'd0);
        tick(2);
        // reset state, disabled then enabled
        chk("rst_ring_dis", ring_counter, 4'b0000);
        chk("rst_blank_dis", {3'b0, blank}, 4'd1);
        enable = 1'b1; #1;
        chk("rst_ring_en", ring_counter, 4'b0001);
        chk("rst_digit", digit_out, 4'd0);
        chk("rst_fd", {3'b0, frame_done}, 4'd0);
        chk("rst_ack", {3'b0, load_ack}, 4'd0);
        chk("rst_blank_en", {3'b0, blank}, 4'd0);
        reset = 1'b0;

        // basic rotation and frame pulse
        tick(3);
        chk("rot_p3_ring", ring_counter, 4'b0001);
        chk("rot_p3_fd", {3'b0, frame_done}, 4'd0);
        tick(1); chk("rot_0010", ring_counter, 4'b0010);
        tick(4); chk("rot_0100", ring_counter, 4'b0100);
        tick(4); chk("rot_1000", ring_counter, 4'b1000);
        tick(2); chk("rot_fd_early", {3'b0, frame_done}, 4'd0);
        tick(1); chk("rot_fd", {3'b0, frame_done}, 4'd1);
        tick(1);
        chk("rot_wrap", ring_counter, 4'b0001);
        chk("rot_fd_clear", {3'b0, frame_done}, 4'd0);

        // mid-frame load 9,3,0,7
        tick(5);
        chk("ld_ring", ring_counter, 4'b0010);
        set_data(4'd9, 4'd3, 4'd0, 4'd7); load = 1'b1;
        tick(1); load = 1'b0; set_data(4'd0, 4'd0, 4'd0, 4'd0); #1;
        chk("ld_hold_digit", digit_out, 4'd0);
        chk("ld_no_ack", {3'b0, load_ack}, 4'd0);
        tick(9);
        chk("ld_bnd_fd", {3'b0, frame_done}, 4'd1);
        chk("ld_bnd_digit", digit_out, 4'd0);
        chk("ld_bnd_ack", {3'b0, load_ack}, 4'd0);
        tick(1);
        chk("ld_ack", {3'b0, load_ack}, 4'd1);
        chk("ld_d0", digit_out, 4'd7);
        tick(1);
        chk("ld_ack_once", {3'b0, load_ack}, 4'd0);
        tick(3); chk("ld_d1", digit_out, 4'd0);
        tick(4); chk("ld_d2", digit_out, 4'd3);
        tick(4);
        chk("ld_d3", digit_out, 4'd9);
        chk("ld_blank", {3'b0, blank}, 4'd0);

        // two loads before one boundary: last wins, single ack
        set_data(4'd1, 4'd1, 4'd1, 4'd1); load = 1'b1;
        tick(1);
        set_data(4'd2, 4'd2, 4'd2, 4'd2);
        tick(1); load = 1'b0; set_data(4'd0, 4'd0, 4'd0, 4'd0);
        tick(1);
        chk("dbl_fd", {3'b0, frame_done}, 4'd1);
        tick(1);
        chk("dbl_ack", {3'b0, load_ack}, 4'd1);
        chk("dbl_d0", digit_out, 4'd2);
        tick(1); chk("dbl_ack_clr", {3'b0, load_ack}, 4'd0);
        tick(3); chk("dbl_d1", digit_out, 4'd2);
        tick(11); chk("dbl_fd2", {3'b0, frame_done}, 4'd1);
        tick(1);
        chk("dbl_no_ack2", {3'b0, load_ack}, 4'd0);
        chk("dbl_d0_b", digit_out, 4'd2);

        // hold at ring 0100, presc 2, with a load while disabled
        tick(10);
        chk("hold_pre_ring", ring_counter, 4'b0100);
        enable = 1'b0; #1;
        chk("hold_ring", ring_counter, 4'b0000);
        chk("hold_blank", {3'b0, blank}, 4'd1);
        set_data(4'd5, 4'd6, 4'd7, 4'd8); load = 1'b1;
        tick(1); load = 1'b0; set_data(4'd0, 4'd0, 4'd0, 4'd0);
        tick(9);
        chk("hold_ring_end", ring_counter, 4'b0000);
        chk("hold_blank_end", {3'b0, blank}, 4'd1);
        chk("hold_fd", {3'b0, frame_done}, 4'd0);
        chk("hold_ack", {3'b0, load_ack}, 4'd0);
        enable = 1'b1; #1;
        chk("res_ring", ring_counter, 4'b0100);
        chk("res_blank", {3'b0, blank}, 4'd0);
        chk("res_digit", digit_out, 4'd2);
        tick(1); chk("res_count_kept", ring_counter, 4'b0100);
        tick(1); chk("res_step", ring_counter, 4'b1000);
        tick(3); chk("res_fd", {3'b0, frame_done}, 4'd1);
        tick(1);
        chk("res_ack", {3'b0, load_ack}, 4'd1);
        chk("res_d0", digit_out, 4'd8);

        // load coincident with boundary: shadow 0,0,4,2
        tick(15);
        chk("coin_fd", {3'b0, frame_done}, 4'd1);
        set_data(4'd0, 4'd0, 4'd4, 4'd2); load = 1'b1;
        tick(1); load = 1'b0; set_data(4'd0, 4'd0, 4'd0, 4'd0); #1;
        chk("coin_ack", {3'b0, load_ack}, 4'd1);
        chk("coin_d0", digit_out, 4'd2);
        chk("coin_blank0", {3'b0, blank}, 4'd0);
        tick(1); chk("coin_ack_clr", {3'b0, load_ack}, 4'd0);
        tick(3);
        chk("coin_d1", digit_out, 4'd4);
        chk("coin_blank1", {3'b0, blank}, 4'd0);
        tick(4);
        chk("coin_d2", digit_out, 4'd0);
        chk("coin_blank2", {3'b0, blank}, {3'b0, LZ});
        tick(4);
        chk("coin_d3", digit_out, 4'd0);
        chk("coin_blank3", {3'b0, blank}, {3'b0, LZ});

        // reset while a load is pending
        set_data(4'd1, 4'd2, 4'd3, 4'd4); load = 1'b1;
        tick(1); load = 1'b0; set_data(4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1; #1;
        chk("prst_ring", ring_counter, 4'b0001);
        chk("prst_digit", digit_out, 4'd0);
        chk("prst_ack", {3'b0, load_ack}, 4'd0);
        tick(2);
        reset = 1'b0;
        tick(15); chk("prst_fd", {3'b0, frame_done}, 4'd1);
        tick(1);
        chk("prst_no_ack", {3'b0, load_ack}, 4'd0);
        chk("prst_d0", digit_out, 4'd0);
        chk("prst_blank0", {3'b0, blank}, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is driven (legal 1..2^20).
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  scan run/hold.
REQ-005 SHALL have port load  input  1  request to capture a new 4-digit value.
REQ-006 SHALL have ports data_3, data_2, data_1, data_0  input  4 each  BCD digits; data_3 most significant.
REQ-007 SHALL have port ring_counter  output  4  one-hot digit select; bit k selects digit k.
REQ-008 SHALL have port digit_out  output  4  shadow nibble of the currently selected digit.
REQ-009 SHALL have port blank  output  1  current digit shall not be lit.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.
REQ-011 SHALL have port load_ack  output  1  one-cycle pulse after the shadow register updates.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 while enable=1; a terminal count is a "step"; SCAN_DIV=1 steps every cycle.
REQ-013 On each step, internal ring SHALL rotate 0001->0010->0100->1000->0001.
REQ-014 Frame boundary SHALL be the step taking the ring from 1000 to 0001; frame_done SHALL be high for that cycle only.
REQ-015 ring_counter SHALL equal the internal ring when enable=1 and 0000 when enable=0.
REQ-016 enable=0 SHALL freeze prescaler and ring; re-assertion SHALL resume from the frozen position and count.
REQ-017 load=1 SHALL copy data_3..data_0 into a staging register in that cycle and set pending.
REQ-018 Shadow register SHALL update only at a frame boundary, and only if pending or load is set; sources are the data inputs if load=1 that cycle, else staging.
REQ-019 A shadow update SHALL clear pending and assert load_ack for exactly the following cycle.
REQ-020 Multiple loads before a boundary SHALL keep only the last value and produce a single load_ack.
REQ-021 A load arriving while enable=0 SHALL stay pending until the next boundary after enable returns.
REQ-022 digit_out SHALL be the shadow nibble indexed by the internal ring, with zero cycles of latency from the ring.
REQ-023 blank SHALL be 1 whenever enable=0.

Reset
REQ-024 reset=1 SHALL immediately force: prescaler 0, ring 0001, staging and shadow 0000 per digit, pending 0.
REQ-025 Output values during and after reset SHALL be: ring_counter 0001 if enable=1 else 0000, digit_out 0000, frame_done 0, load_ack 0, blank per REQ-023 and REQ-027.
REQ-026 Reset during a pending load SHALL discard the load; no load_ack shall follow.

Configuration
REQ-027 With LEADING_ZERO_BLANK_EN defined, blank SHALL also be 1 for digit k (k=1..3) when shadow digits 3..k are all 0000; digit 0 is never suppressed.
REQ-028 Without LEADING_ZERO_BLANK_EN, blank SHALL equal ~enable only.

Verification (SCAN_DIV=4)
REQ-029 Reset, enable=1 -> ring_counter 0001,0010,0100,1000,0001 every 4 cycles; frame_done pulses on the 1000->0001 step.
REQ-030 Load 9,3,0,7 mid-frame -> digit_out unchanged until the boundary; then load_ack for 1 cycle, and digit_out per slot = 7,0,3,9 for digits 0..3.
REQ-031 Loads of 1111 then 2222 before a boundary -> single load_ack; shadow=2222.
REQ-032 enable low for 10 cycles at ring 0100 -> ring_counter 0000, blank=1; ring resumes at 0100 with the prescaler count preserved.
REQ-033 Load coincident with boundary -> shadow takes that cycle's inputs; load_ack next cycle.
REQ-034 With LEADING_ZERO_BLANK_EN, shadow 0,0,4,2 (d3..d0) -> blank=1 at ring 1000 and 0100, blank=0 at ring 0010 and 0001; reset asserted mid-pending -> no load_ack.
